sigmoid_pwl_pipe: RTL

Pipelined, multi-lane piecewise-linear sigmoid for the activation stage of the neural datapath. It uses the 4-slice PLAN approximation in signed fixed point, with the widths parametrised. The block processes LANES samples per beat behind a valid/ready handshake, with a fixed 3-cycle latency. It replaces the single combinational sigmoid slice wherever activations are streamed between layer engines.

---
 rtl/sigmoid_pkg.sv | 44 ++++
 rtl/sigmoid_pwl_lane.sv | 114 +++++++++++
 rtl/sigmoid_pwl_pipe.sv | 55 +++++
 3 files changed

// File: rtl/sigmoid_pkg.sv
// Shared constants for the PLAN piecewise-linear sigmoid: fixed-point breakpoints,
// offsets and slope shifts as functions of the fraction width, plus the slice encoding.
package sigmoid_pkg;

  typedef enum logic [1:0] {
    SLICE_CTR = 2'd0,
    SLICE_MID = 2'd1,
    SLICE_OUT = 2'd2,
    SLICE_SAT = 2'd3
  } slice_e;

  localparam int SHIFT_CTR = 2;
  localparam int SHIFT_MID = 3;
  localparam int SHIFT_OUT = 5;

  function automatic longint one_f(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint bp_1p0_f(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint bp_2p375_f(input int frac);
    return longint'(19) << (frac - 3);
  endfunction

  function automatic longint bp_5p0_f(input int frac);
    return longint'(5) << frac;
  endfunction

  function automatic longint off_0p5_f(input int frac);
    return longint'(1) << (frac - 1);
  endfunction

  function automatic longint off_0p625_f(input int frac);
    return longint'(5) << (frac - 3);
  endfunction

  function automatic longint off_0p84375_f(input int frac);
    return longint'(27) << (frac - 5);
  endfunction

endpackage

// File: rtl/sigmoid_pwl_lane.sv
// One lane of the 3-stage PWL sigmoid datapath; stage registers load only on valid beats.
// SIGMOID_ROUND_EN selects round-half-up slope shifts instead of truncation.
module sigmoid_pwl_lane
  import sigmoid_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_p0,
  input  logic                    ld_p1,
  input  logic                    ld_p2,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(one_f(FRAC));
  localparam logic signed [WIDTH:0]   ONE_X   = (WIDTH+1)'(one_f(FRAC));
  localparam logic signed [WIDTH-1:0] BP_1P0  = WIDTH'(bp_1p0_f(FRAC));
  localparam logic signed [WIDTH-1:0] BP_2P375 = WIDTH'(bp_2p375_f(FRAC));
  localparam logic signed [WIDTH-1:0] BP_5P0  = WIDTH'(bp_5p0_f(FRAC));
  localparam logic signed [WIDTH:0]   OFF_CTR = (WIDTH+1)'(off_0p5_f(FRAC));
  localparam logic signed [WIDTH:0]   OFF_MID = (WIDTH+1)'(off_0p625_f(FRAC));
  localparam logic signed [WIDTH:0]   OFF_OUT = (WIDTH+1)'(off_0p84375_f(FRAC));
  localparam logic signed [WIDTH-1:0] MAXPOS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINNEG  = {1'b1, {(WIDTH-1){1'b0}}};

  // |v|, with the most negative code folded onto the largest positive one
  function automatic logic signed [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] v);
    if (v == MINNEG) return MAXPOS;
    else if (v < 0)  return -v;
    else             return v;
  endfunction

`ifdef SIGMOID_ROUND_EN
  function automatic logic signed [WIDTH-1:0] slope(input logic signed [WIDTH-1:0] v,
                                                    input int s);
    logic [WIDTH:0] t;
    t = {1'b0, v} + ((WIDTH+1)'(1) << (s - 1));
    return WIDTH'(t >> s);
  endfunction
`else
  function automatic logic signed [WIDTH-1:0] slope(input logic signed [WIDTH-1:0] v,
                                                    input int s);
    return v >>> s;
  endfunction
`endif

  function automatic logic signed [WIDTH-1:0] sat_unit(input logic signed [WIDTH:0] v);
    if (v < 0)          return '0;
    else if (v > ONE_X) return ONE;
    else                return WIDTH'(v);
  endfunction

  logic                    sign_p0, sign_p1;
  logic signed [WIDTH-1:0] a_p0;
  slice_e                  slice_nx, slice_p1;
  logic signed [WIDTH-1:0] term_nx, term_p1;
  logic signed [WIDTH:0]   off_nx, sum_nx;
  logic signed [WIDTH-1:0] unit_nx, mir_nx, y_p2;

  // S1: sign and magnitude
  always_ff @(posedge clk) begin
    if (ld_p0) begin
      sign_p0 <= x[WIDTH-1];
      a_p0    <= abs_sat(x);
    end
  end

  always_comb begin
    slice_nx = SLICE_CTR;
    term_nx  = slope(a_p0, SHIFT_CTR);
    if (a_p0 >= BP_5P0) begin
      slice_nx = SLICE_SAT;
      term_nx  = '0;
    end else if (a_p0 >= BP_2P375) begin
      slice_nx = SLICE_OUT;
      term_nx  = slope(a_p0, SHIFT_OUT);
    end else if (a_p0 >= BP_1P0) begin
      slice_nx = SLICE_MID;
      term_nx  = slope(a_p0, SHIFT_MID);
    end
  end

  // S2: slice select and shifted term
  always_ff @(posedge clk) begin
    if (ld_p1) begin
      sign_p1  <= sign_p0;
      slice_p1 <= slice_nx;
      term_p1  <= term_nx;
    end
  end

  always_comb begin
    unique case (slice_p1)
      SLICE_MID: off_nx = OFF_MID;
      SLICE_OUT: off_nx = OFF_OUT;
      default:   off_nx = OFF_CTR;
    endcase
    sum_nx  = (WIDTH+1)'(term_p1) + off_nx;
    unit_nx = (slice_p1 == SLICE_SAT) ? ONE : sat_unit(sum_nx);
    mir_nx  = sign_p1 ? (ONE - unit_nx) : unit_nx;
  end

  // S3: offset, mirror, output register
  always_ff @(posedge clk) begin
    if (rst)        y_p2 <= '0;
    else if (ld_p2) y_p2 <= mir_nx;
  end

  assign y = y_p2;

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// Multi-lane pipelined PWL sigmoid, fixed 3-stage latency, single valid/ready handshake.
// Define SIGMOID_ROUND_EN for round-half-up slope shifts (default build truncates).
module sigmoid_pwl_pipe
  import sigmoid_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 27,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data
);

  logic adv;
  logic vld_p0, vld_p1, vld_p2;

  // The whole pipe moves as one; bubbles advance like beats
  assign adv       = !vld_p2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sigmoid_pwl_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .ld_p0 (adv && in_valid),
      .ld_p1 (adv && vld_p0),
      .ld_p2 (adv && vld_p1),
      .x     (in_data[i*WIDTH +: WIDTH]),
      .y     (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule
